imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream writer for the 16-bit CPU's instruction memory. It accepts a length-prefixed program image over a valid/ready byte interface, assembles big-endian 16-bit words and writes them to consecutive word addresses from 0. It holds the CPU in reset until the image is complete. It is the write-side counterpart of the CPU's instruction fetch port and sits between the external programming link and the IMemory write port.

## Interface
- `ADDR_W`, default 10: IMemory word-address width.
- `DEPTH`, default 1024: IMemory capacity in words. Must be ≤ 2^ADDR_W.
- `clock` input 1: single clock. All state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_byte` holds a valid byte.
- `in_byte` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `start` input 1: one-cycle pulse that restarts loading from `DONE` or `ERR`.
- `imem_we` output 1: IMemory write strobe, one cycle per word.
- `imem_addr` output ADDR_W: word address for the write.
- `imem_wdata` output 16: word to write.
- `cpu_hold` output 1: holds the CPU/PC in reset while high.
- `done` output 1: image fully loaded.
- `error` output 1: image rejected.

## Operation
- **Accept rule.** A byte is accepted on an edge where `in_valid && in_ready`. `in_ready` is combinational from state only:
  - 1 in `CNT_HI`, `CNT_LO`, `DATA_HI`, `DATA_LO`, `CHK`.
  - 0 in `DONE`, `ERR`.
- **States:**
  - `CNT_HI`: latch count[15:8].
  - `CNT_LO`: latch count[7:0]. Then:
    - count > DEPTH → `ERR`.
    - count = 0 → `CHK` if checksum is enabled, else `DONE`.
    - otherwise → `DATA_HI`.
  - `DATA_HI`: latch word[15:8].
  - `DATA_LO`: form the word and issue the write. Then:
    - if this was the last word → `CHK` or `DONE`.
    - otherwise → `DATA_HI`.
  - `CHK`: compare the received byte with the running checksum. Match → `DONE`, mismatch → `ERR`.
  - `DONE`, `ERR`: wait for `start`, then go to `CNT_HI`. Entering `CNT_HI` clears the word counter, the checksum and the `done`/`error` flags.
- **`start` outside `DONE`/`ERR`:** ignored.
- **Word counter:** ADDR_W+1 bits, 0..count. The write address is the counter's low ADDR_W bits. No wrap is possible because count ≤ DEPTH is checked first.
- **Outputs:**
  - `cpu_hold` = 1 in every state except `DONE`. It stays 1 in `ERR`.
  - `done` = state is `DONE`.
  - `error` = state is `ERR`.
- **Stalls:** a cycle with `in_valid` low between any two bytes has no effect on state.

## Timing
- **Reset values:**
  - State: `CNT_HI`.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_hold` = 1, `done` = 0, `error` = 0.
  - Internal counter and checksum: 0.
- **Write timing:**
  - `imem_we`, `imem_addr` and `imem_wdata` are registered.
  - The low byte of word k is accepted at edge E. The outputs show k / word for exactly one cycle after E.
  - `imem_we` is otherwise 0.
  - `imem_addr` and `imem_wdata` hold their last values while `imem_we` = 0.
- **Release timing:** `done` rises and `cpu_hold` falls in the same cycle as the last `imem_we`, or the cycle after the `CHK` byte is accepted. IMemory samples the final write at the same edge that the CPU first leaves reset.
- **Throughput:** one byte per cycle maximum, i.e. one word per two cycles.
- **`reset_n` low mid-image:** immediate return to reset values. Any partial word is discarded and no write is issued.
- **Restart:** `start` in `DONE` at edge E gives `cpu_hold` = 1 and `done` = 0 from E onward.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - One trailer byte follows the data: the XOR of all data bytes, excluding the count bytes.
  - State `CHK` exists. A mismatch goes to `ERR`. Words already written remain in IMemory.
  - Count = 0 still expects a trailer of 0x00.
- **Undefined:**
  - No `CHK` state and no trailer byte.
  - `DONE` follows the last `DATA_LO` directly.
  - `ERR` is reachable only on count > DEPTH.

## Test plan
1. Reset, then stream 00 02 40 01 40 0F (checksum off) → writes addr0 = 0x4001, addr1 = 0x400F on consecutive strobe cycles. `done` = 1 and `cpu_hold` = 0 together with the addr1 strobe.
2. Same stream with gaps of 3 idle cycles between bytes → identical writes and values. `imem_we` is high for exactly 2 cycles in total.
3. Count 04 01 (1025) with DEPTH = 1024 → `ERR`, no `imem_we`, `cpu_hold` stays 1, `in_ready` = 0. Then `start` → `CNT_HI` with `error` = 0.
4. Checksum on: stream 00 01 12 34 26 → addr0 = 0x1234, `done`. Repeat with trailer 27 → `error` = 1, `cpu_hold` = 1.
5. `reset_n` pulsed low after 00 03 AB → no write issued, all outputs at reset values. A fresh 00 01 FF 00 then writes addr0 = 0xFF00.
6. Count 00 00 (checksum off) → `done` on the cycle after the second count byte, zero writes. `start` during `DATA_HI` of a later load → ignored.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and IMemory write-port bundle for imem_loader.
// The loader sits on the slave modport; the programming link / memory model on master.
interface imem_loader_if #(
   parameter int ADDR_W = 10
) ();
   logic              in_valid;
   logic [7:0]        in_byte;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;

   modport master (
      output in_valid, in_byte,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_byte,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian word image into IMemory and holds the CPU in reset until done.
// Optional trailer checksum (XOR of data bytes) enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   imem_loader_if.slave bus,
   output logic         cpu_hold,
   output logic         done,
   output logic         error
);
   localparam int CW = ADDR_W + 1;

   typedef enum logic [2:0] {
      CNT_HI,
      CNT_LO,
      DATA_HI,
      DATA_LO,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

   state_t            state_reg;
   logic [15:0]       count_reg;
   logic [7:0]        hi_reg;
   logic [CW-1:0]     word_cnt_reg;
   logic              imem_we_reg;
   logic [ADDR_W-1:0] imem_addr_reg;
   logic [15:0]       imem_wdata_reg;
   logic              cpu_hold_reg;
   logic              done_reg;
   logic              error_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        chk_reg;
`endif

   logic        in_ready_int;
   logic        accept;
   logic [15:0] cnt_full;
   logic        cnt_over;
   logic        last_word;

   assign in_ready_int = (state_reg != DONE) && (state_reg != ERR);
   assign accept       = bus.in_valid && in_ready_int;
   assign cnt_full     = {count_reg[15:8], bus.in_byte};
   assign cnt_over     = 32'(cnt_full) > 32'(DEPTH);
   // The word being written now is the last one when counter+1 reaches the count.
   assign last_word    = (32'(word_cnt_reg) + 32'd1) == 32'(count_reg);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= CNT_HI;
         count_reg      <= '0;
         hi_reg         <= '0;
         word_cnt_reg   <= '0;
         imem_we_reg    <= 1'b0;
         imem_addr_reg  <= '0;
         imem_wdata_reg <= '0;
         cpu_hold_reg   <= 1'b1;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_reg        <= '0;
`endif
      end else begin
         imem_we_reg <= 1'b0;
         case (state_reg)
            CNT_HI: if (accept) begin
               count_reg[15:8] <= bus.in_byte;
               state_reg       <= CNT_LO;
            end
            CNT_LO: if (accept) begin
               count_reg[7:0] <= bus.in_byte;
               if (cnt_over) begin
                  state_reg <= ERR;
                  error_reg <= 1'b1;
               end else if (cnt_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_reg <= CHK;
`else
                  state_reg    <= DONE;
                  done_reg     <= 1'b1;
                  cpu_hold_reg <= 1'b0;
`endif
               end else begin
                  state_reg <= DATA_HI;
               end
            end
            DATA_HI: if (accept) begin
               hi_reg    <= bus.in_byte;
               state_reg <= DATA_LO;
            end
            DATA_LO: if (accept) begin
               imem_we_reg    <= 1'b1;
               imem_addr_reg  <= word_cnt_reg[ADDR_W-1:0];
               imem_wdata_reg <= {hi_reg, bus.in_byte};
               word_cnt_reg   <= word_cnt_reg + CW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_reg        <= chk_reg ^ hi_reg ^ bus.in_byte;
`endif
               if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_reg <= CHK;
`else
                  // Release coincides with the final strobe so the CPU starts as the word lands.
                  state_reg    <= DONE;
                  done_reg     <= 1'b1;
                  cpu_hold_reg <= 1'b0;
`endif
               end else begin
                  state_reg <= DATA_HI;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (accept) begin
               if (bus.in_byte == chk_reg) begin
                  state_reg    <= DONE;
                  done_reg     <= 1'b1;
                  cpu_hold_reg <= 1'b0;
               end else begin
                  state_reg <= ERR;
                  error_reg <= 1'b1;
               end
            end
`endif
            DONE, ERR: if (start) begin
               state_reg    <= CNT_HI;
               word_cnt_reg <= '0;
               done_reg     <= 1'b0;
               error_reg    <= 1'b0;
               cpu_hold_reg <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_reg      <= '0;
`endif
            end
            default: state_reg <= CNT_HI;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_int;
   assign bus.imem_we    = imem_we_reg;
   assign bus.imem_addr  = imem_addr_reg;
   assign bus.imem_wdata = imem_wdata_reg;
   assign cpu_hold       = cpu_hold_reg;
   assign done           = done_reg;
   assign error          = error_reg;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: image-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CHK_EN = 1;
`else
   localparam int CHK_EN = 0;
`endif
   localparam int WL = 4096;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic start   = 1'b0;
   logic cpu_hold, done, error;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .bus     (bus),
      .cpu_hold(cpu_hold),
      .done    (done),
      .error   (error)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the bytes accepted for the current image, judged as a whole.
   logic [7:0]        img[$];
   logic              m_we    = 1'b0;
   logic [ADDR_W-1:0] m_addr  = '0;
   logic [15:0]       m_wdata = '0;

   function automatic int img_count();
      if (img.size() < 2) return 0;
      return int'({img[0], img[1]});
   endfunction

   // 0 = still loading, 1 = done, 2 = rejected
   function automatic int img_status();
      int c, need;
      logic [7:0] x;
      if (img.size() < 2) return 0;
      c = img_count();
      if (c > DEPTH) return 2;
      need = 2 + 2 * c + CHK_EN;
      if (img.size() < need) return 0;
      if (CHK_EN != 0) begin
         x = 8'h00;
         for (int i = 2; i < 2 + 2 * c; i++) x ^= img[i];
         if (x != img[need-1]) return 2;
      end
      return 1;
   endfunction

   always @(posedge clock) begin : model_proc
      int st, n, k;
      if (!reset_n) begin
         img.delete();
         m_we    = 1'b0;
         m_addr  = '0;
         m_wdata = '0;
      end else begin
         st   = img_status();
         m_we = 1'b0;
         if (st != 0) begin
            if (start) img.delete();
         end else if (bus.in_valid) begin
            img.push_back(bus.in_byte);
            n = img.size();
            if (n >= 4 && n % 2 == 0 && n <= 2 + 2 * img_count()) begin
               k       = (n - 4) / 2;
               m_we    = 1'b1;
               m_addr  = ADDR_W'(k);
               m_wdata = {img[n-2], img[n-1]};
            end
         end
      end
   end

   always @(negedge clock) begin : compare_proc
      int st;
      if (reset_n) begin
         st = img_status();
         check("in_ready", bus.in_ready, st == 0);
         check("cpu_hold", cpu_hold, st != 1);
         check("done", done, st == 1);
         check("error", error, st == 2);
         check("imem_we", bus.imem_we, m_we);
         check("imem_addr", bus.imem_addr, m_addr);
         check("imem_wdata", bus.imem_wdata, m_wdata);
      end
   end

   // Log of writes actually issued, for the literal checks.
   logic [15:0]       wl_data [WL];
   logic [ADDR_W-1:0] wl_addr [WL];
   logic              wl_done [WL];
   int                wl_n = 0;

   always @(negedge clock) begin : logger_proc
      if (reset_n && bus.imem_we) begin
         wl_data[wl_n % WL] = bus.imem_wdata;
         wl_addr[wl_n % WL] = bus.imem_addr;
         wl_done[wl_n % WL] = done;
         wl_n++;
      end
   end

   logic [7:0] tx[$];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_tx(input int gmin, input int gmax, input bit rand_start);
      foreach (tx[i]) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(gmax, gmin)) tick();
         bus.in_valid = 1'b1;
         bus.in_byte  = tx[i];
         start        = rand_start && ($urandom_range(7, 0) == 0);
         tick();
         bus.in_valid = 1'b0;
         bus.in_byte  = 8'($urandom);
         start        = 1'b0;
      end
   endtask

   task automatic add_trailer();
      logic [7:0] x;
      x = 8'h00;
      if (CHK_EN != 0) begin
         for (int i = 2; i < tx.size(); i++) x ^= tx[i];
         tx.push_back(x);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int base, cnt, r, st;
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;

      // Reset values
      tick(); tick();
      check("rst_we", bus.imem_we, 0);
      check("rst_addr", bus.imem_addr, 0);
      check("rst_wdata", bus.imem_wdata, 0);
      check("rst_hold", cpu_hold, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      reset_n = 1'b1;
      tick();
      check("rst_ready", bus.in_ready, 1);

      // Two-word image, back to back
      base = wl_n;
      tx = {8'h00, 8'h02, 8'h40, 8'h01, 8'h40, 8'h0F};
      add_trailer();
      send_tx(0, 0, 0);
      check("t1_done", done, 1);
      check("t1_hold", cpu_hold, 0);
      tick(); tick();
      check("t1_nwr", wl_n - base, 2);
      check("t1_a0", wl_addr[base % WL], 0);
      check("t1_d0", wl_data[base % WL], 16'h4001);
      check("t1_a1", wl_addr[(base + 1) % WL], 1);
      check("t1_d1", wl_data[(base + 1) % WL], 16'h400F);
      check("t1_done_at_we", wl_done[(base + 1) % WL], CHK_EN == 0);
      $display("[TB] t1 two-word image, writes=%0d", wl_n - base);

      // Same image with 3 idle cycles between bytes
      pulse_start();
      base = wl_n;
      tx = {8'h00, 8'h02, 8'h40, 8'h01, 8'h40, 8'h0F};
      add_trailer();
      send_tx(3, 3, 0);
      tick(); tick();
      check("t2_nwr", wl_n - base, 2);
      check("t2_d0", wl_data[base % WL], 16'h4001);
      check("t2_d1", wl_data[(base + 1) % WL], 16'h400F);
      check("t2_done", done, 1);
      $display("[TB] t2 gapped image, writes=%0d", wl_n - base);

      // Oversize count
      pulse_start();
      base = wl_n;
      tx = {8'h04, 8'h01};
      send_tx(0, 0, 0);
      tick();
      check("t3_error", error, 1);
      check("t3_hold", cpu_hold, 1);
      check("t3_ready", bus.in_ready, 0);
      check("t3_nwr", wl_n - base, 0);
      pulse_start();
      check("t3_restart_error", error, 0);
      check("t3_restart_ready", bus.in_ready, 1);
      $display("[TB] t3 count 1025 rejected");

      // One-word image, good trailer (and a bad one when checksum is in)
      tx = {8'h00, 8'h01, 8'h12, 8'h34};
      add_trailer();
      send_tx(0, 1, 0);
      check("t4_done", done, 1);
      tick(); tick();
      check("t4_d0", wl_data[(wl_n - 1) % WL], 16'h1234);
      check("t4_a0", wl_addr[(wl_n - 1) % WL], 0);
      pulse_start();
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("t4_trailer", tx[4], 8'h26);
      tx = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
      send_tx(0, 1, 0);
      check("t4_bad_error", error, 1);
      check("t4_bad_hold", cpu_hold, 1);
      pulse_start();
`endif
      $display("[TB] t4 one-word image");

      // Reset mid-image
      base = wl_n;
      tx = {8'h00, 8'h03, 8'hAB};
      send_tx(0, 0, 0);
      reset_n = 1'b0;
      #1;
      check("t5_we", bus.imem_we, 0);
      check("t5_addr", bus.imem_addr, 0);
      check("t5_wdata", bus.imem_wdata, 0);
      check("t5_hold", cpu_hold, 1);
      check("t5_done", done, 0);
      check("t5_error", error, 0);
      check("t5_nwr", wl_n - base, 0);
      tick(); tick();
      reset_n = 1'b1;
      tick();
      tx = {8'h00, 8'h01, 8'hFF, 8'h00};
      add_trailer();
      send_tx(0, 0, 0);
      tick(); tick();
      check("t5_d0", wl_data[(wl_n - 1) % WL], 16'hFF00);
      check("t5_post_done", done, 1);
      $display("[TB] t5 reset mid-image then reload");

      // Empty image; start ignored mid-load
      pulse_start();
      base = wl_n;
      tx = {8'h00, 8'h00};
      add_trailer();
      send_tx(0, 0, 0);
      check("t6_done", done, 1);
      tick();
      check("t6_nwr", wl_n - base, 0);
      pulse_start();
      tx = {8'h00, 8'h01};
      send_tx(0, 0, 0);
      pulse_start();
      check("t6_ign_hold", cpu_hold, 1);
      check("t6_ign_ready", bus.in_ready, 1);
      tx = {8'hAA, 8'hBB};
      if (CHK_EN != 0) tx.push_back(8'h11);
      send_tx(0, 0, 0);
      tick(); tick();
      check("t6_d0", wl_data[(wl_n - 1) % WL], 16'hAABB);
      check("t6_ign_done", done, 1);
      $display("[TB] t6 empty image and ignored start");

      // Full-depth image
      pulse_start();
      base = wl_n;
      tx = {8'h04, 8'h00};
      for (int i = 0; i < 2 * DEPTH; i++) tx.push_back(8'($urandom));
      add_trailer();
      send_tx(0, 0, 0);
      tick(); tick();
      check("tdepth_done", done, 1);
      check("tdepth_nwr", wl_n - base, DEPTH);
      check("tdepth_last_addr", wl_addr[(wl_n - 1) % WL], DEPTH - 1);
      $display("[TB] full-depth image, writes=%0d", wl_n - base);

      // Randomized images
      for (int n = 0; n < 60; n++) begin
         pulse_start();
         base = wl_n;
         r = $urandom_range(15, 0);
         cnt = (r == 0) ? $urandom_range(65535, DEPTH + 1) : $urandom_range(6, 0);
         tx = {8'(cnt >> 8), 8'(cnt)};
         if (cnt <= DEPTH) begin
            for (int i = 0; i < 2 * cnt; i++) tx.push_back(8'($urandom));
            add_trailer();
            if (CHK_EN != 0 && r == 1) tx[tx.size() - 1] ^= 8'($urandom_range(255, 1));
         end
         send_tx(0, 3, 1);
         repeat ($urandom_range(3, 1)) tick();
         st = img_status();
         $display("[TB] image %0d count %0d status %0d writes %0d", n, cnt, st, wl_n - base);
      end

      tick(); tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
